// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types for the MIPS bus master.
//   size_t     - access size encoding used by the core request port
//   state_t    - bus master FSM states
//   req_t      - latched core request
//   misaligned - true when an access crosses its natural alignment
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } req_t;

  // The unused encoding 2'b11 is treated as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      default:   misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_master_lane_align.sv
// mips_bus_lane_align: combinational little-endian byte-lane steering.
//   i_off    - address bits [1:0]
//   i_size   - SIZE_BYTE/SIZE_HALF/SIZE_WORD
//   i_signed - sign-extend sub-word loads
//   i_wdata  - right-justified store data
//   i_rdata  - raw bus read word
//   o_be     - byte enables
//   o_wdata  - store data moved onto its lanes, other lanes zero
//   o_rdata  - load data right-justified and extended
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_sh;
  logic [31:0] w_rd_sh;

  assign w_sh    = {i_off, 3'b000};
  assign w_rd_sh = i_rdata >> w_sh;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = w_rd_sh;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {24'h0, i_wdata[7:0]} << w_sh;
        o_rdata = {{24{i_signed & w_rd_sh[7]}}, w_rd_sh[7:0]};
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {16'h0, i_wdata[15:0]} << w_sh;
        o_rdata = {{16{i_signed & w_rd_sh[15]}}, w_rd_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_bus_master.sv
// mips_bus_master: turns one core load/store/fetch into one Avalon-style
// bus transaction and returns a one-cycle response or error pulse.
//   i_clk, i_reset          - clock, synchronous active-high reset
//   i_req .. i_req_wdata    - core request, sampled only while o_busy=0
//   o_busy                  - transaction in flight
//   o_resp_valid/o_resp_rdata - completion pulse, extended load data (held)
//   o_err_misaligned/o_err_timeout - one-cycle error pulses
//   o_address .. o_writedata, i_waitrequest, i_readdata - bus master side
module mips_bus_master
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_wdata,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_err_misaligned,
  output logic        o_err_timeout,
  output logic [31:0] o_address,
  output logic        o_read,
  output logic        o_write,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  input  logic        i_waitrequest,
  input  logic [31:0] i_readdata
);

  localparam logic [CNT_W-1:0] LP_TO = CNT_W'(TIMEOUT_CYCLES);

  state_t            r_state, w_state_nxt;
  req_t              r_req;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_to;
  logic [31:0]       r_resp_rdata;
  logic              w_misal;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata_ext;

  assign w_misal = misaligned(i_req_size, i_req_addr[1:0]);

  // Steering works off the latched request so the bus stays stable
  // for the whole stall.
  mips_bus_lane_align u_align (
    .i_off    (r_req.addr[1:0]),
    .i_size   (r_req.size),
    .i_signed (r_req.sgn),
    .i_wdata  (r_req.wdata),
    .i_rdata  (i_readdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_req) w_state_nxt = w_misal ? ST_ERR : ST_BUS;
      // Completion wins over timeout when both happen in one cycle.
      ST_BUS: begin
        if (!i_waitrequest)     w_state_nxt = ST_RESP;
        else if (r_cnt == LP_TO) w_state_nxt = ST_ERR;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_cnt        <= '0;
      r_err_to     <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_req) begin
            r_err_to <= 1'b0;
            if (!w_misal) begin
              r_req.write <= i_req_write;
              r_req.addr  <= i_req_addr;
              r_req.size  <= i_req_size;
              r_req.sgn   <= i_req_signed;
              r_req.wdata <= i_req_wdata;
            end
          end
        end
        ST_BUS: begin
          if (i_waitrequest) begin
            r_cnt    <= r_cnt + 1'b1;
            r_err_to <= (r_cnt == LP_TO);
          end else if (!r_req.write) begin
            r_resp_rdata <= w_rdata_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy           = (r_state != ST_IDLE);
  assign o_resp_valid     = (r_state == ST_RESP);
  assign o_resp_rdata     = r_resp_rdata;
  assign o_err_misaligned = (r_state == ST_ERR) && !r_err_to;
  assign o_err_timeout    = (r_state == ST_ERR) &&  r_err_to;
  assign o_address        = {r_req.addr[31:2], 2'b00};
  assign o_read           = (r_state == ST_BUS) && !r_req.write;
  assign o_write          = (r_state == ST_BUS) &&  r_req.write;
  assign o_byteenable     = (r_state == ST_BUS) ? w_be : 4'h0;
  assign o_writedata      = ((r_state == ST_BUS) && r_req.write) ? w_wdata : 32'h0;

endmodule

// File: tb/tb_mips_bus_master.sv
// tb_mips_bus_master: randomized bench with a transaction-level model.
// The model predicts, per transaction, which cycles (relative to the
// request cycle) carry busy, the strobe, the response or the error, and
// what lanes/data the bus must show, from a byte-array memory image.
module tb_mips_bus_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        i_reset, i_req, i_req_write, i_req_signed;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [1:0]  i_req_size;
  logic        o_busy, o_resp_valid, o_err_misaligned, o_err_timeout;
  logic [31:0] o_resp_rdata, o_address, o_writedata;
  logic        o_read, o_write;
  logic [3:0]  o_byteenable;
  logic        i_waitrequest;
  logic [31:0] i_readdata;

  mips_bus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .i_req_wdata(i_req_wdata), .o_busy(o_busy), .o_resp_valid(o_resp_valid),
    .o_resp_rdata(o_resp_rdata), .o_err_misaligned(o_err_misaligned),
    .o_err_timeout(o_err_timeout), .o_address(o_address), .o_read(o_read),
    .o_write(o_write), .o_byteenable(o_byteenable), .o_writedata(o_writedata),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic chk_en = 1'b0;

  // model memory (from requests) and slave memory (from the bus)
  logic [7:0] mmem [0:63];
  logic [7:0] smem [0:63];

  // current transaction as predicted by the model
  int          tx_t0 = -1000, tx_end = 0, tx_slast = 0, tx_N = 0, tx_kind = 0;
  logic        tx_write = 1'b0;
  logic [31:0] tx_addr = '0, tx_wd = '0, tx_rdata = '0;
  logic [3:0]  tx_be = '0;
  logic [31:0] held = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // slave: store lanes on completion
  always @(posedge clk) begin
    if (!i_reset && o_write && !i_waitrequest)
      for (int i = 0; i < 4; i++)
        if (o_byteenable[i]) smem[int'(o_address[5:0]) + i] = o_writedata[8*i +: 8];
  end

  int   ck;
  logic e_busy, e_stb, e_rv, e_em, e_et;
  always @(negedge clk) begin
    if (chk_en) begin
      ck     = cyc - tx_t0;
      e_busy = (ck >= 1) && (ck <= tx_end);
      e_stb  = (tx_kind != 1) && (ck >= 1) && (ck <= tx_slast);
      e_rv   = (tx_kind == 0) && (ck == tx_N + 2);
      e_em   = (tx_kind == 1) && (ck == 1);
      e_et   = (tx_kind == 2) && (ck == TO + 2);
      if (e_rv && !tx_write) held = tx_rdata;
      chk("busy",           32'(o_busy),           32'(e_busy));
      chk("read",           32'(o_read),           32'(e_stb && !tx_write));
      chk("write",          32'(o_write),          32'(e_stb && tx_write));
      chk("resp_valid",     32'(o_resp_valid),     32'(e_rv));
      chk("err_misaligned", 32'(o_err_misaligned), 32'(e_em));
      chk("err_timeout",    32'(o_err_timeout),    32'(e_et));
      chk("resp_rdata",     o_resp_rdata,          held);
      if (e_stb) begin
        chk("address",    o_address,          tx_addr & 32'hFFFF_FFFC);
        chk("byteenable", 32'(o_byteenable),  32'(tx_be));
        chk("writedata",  o_writedata,        tx_write ? tx_wd : 32'h0);
      end
    end
  end

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, input int n);
    int nb, off, a6, kind, nn, e, sl;
    logic misal;
    logic [3:0]  be;
    logic [31:0] wl, v;
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    a6    = int'(addr[5:0]);
    misal = ((nb == 2) && (off % 2 != 0)) || ((nb == 4) && (off != 0));
    kind  = misal ? 1 : (n > TO) ? 2 : 0;
    nn    = (kind == 2) ? TO + 1 : n;
    be = '0; wl = '0; v = '0;
    if (!misal)
      for (int i = 0; i < nb; i++) begin
        be[off + i]          = 1'b1;
        wl[8*(off + i) +: 8] = wd[8*i +: 8];
        v[8*i +: 8]          = mmem[a6 + i];
      end
    if (sg && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sg && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
    if (kind == 0 && wr)
      for (int i = 0; i < nb; i++) mmem[a6 + i] = wd[8*i +: 8];
    e  = (kind == 1) ? 1 : (kind == 2) ? TO + 2 : nn + 2;
    sl = (kind == 2) ? TO + 1 : nn + 1;
    @(posedge clk); #1;
    tx_t0 = cyc; tx_kind = kind; tx_N = nn; tx_end = e; tx_slast = sl;
    tx_write = wr; tx_addr = addr; tx_be = be; tx_wd = wl; tx_rdata = v;
    i_req = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_size = sz;
    i_req_signed = sg; i_req_wdata = wd;
    i_waitrequest = 1'($urandom); i_readdata = $urandom;
    for (int k = 1; k <= e; k++) begin
      @(posedge clk); #1;
      // junk requests while busy must be ignored
      i_req = 1'($urandom); i_req_write = 1'($urandom); i_req_addr = $urandom;
      i_req_size = 2'($urandom_range(0, 2)); i_req_signed = 1'($urandom);
      i_req_wdata = $urandom;
      if (kind != 1 && k <= nn) begin
        i_waitrequest = 1'b1; i_readdata = $urandom;
      end else if (kind == 0 && k == nn + 1) begin
        a6 = int'(o_address[5:0]);
        i_waitrequest = 1'b0;
        i_readdata = {smem[a6 + 3], smem[a6 + 2], smem[a6 + 1], smem[a6]};
      end else begin
        i_waitrequest = 1'($urandom); i_readdata = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_req = 1'b0; i_waitrequest = 1'($urandom); i_readdata = $urandom;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] exp);
    @(negedge clk);
    chk(nm, o_resp_rdata, exp);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(o_busy), 0);
    chk({nm, "_rv"},   32'(o_resp_valid), 0);
    chk({nm, "_rd"},   o_resp_rdata, 0);
    chk({nm, "_em"},   32'(o_err_misaligned), 0);
    chk({nm, "_et"},   32'(o_err_timeout), 0);
    chk({nm, "_addr"}, o_address, 0);
    chk({nm, "_rdstb"}, 32'(o_read), 0);
    chk({nm, "_wrstb"}, 32'(o_write), 0);
    chk({nm, "_be"},   32'(o_byteenable), 0);
    chk({nm, "_wd"},   o_writedata, 0);
  endtask

  logic [31:0] ra;
  initial begin
    i_reset = 1'b1; i_req = 1'b0; i_req_write = 1'b0; i_req_addr = '0;
    i_req_size = 2'd0; i_req_signed = 1'b0; i_req_wdata = '0;
    i_waitrequest = 1'b0; i_readdata = '0;
    for (int i = 0; i < 64; i++) begin mmem[i] = 8'h0; smem[i] = 8'h0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    i_reset = 1'b0; chk_en = 1'b1;

    // directed: bytes 4..7 = 66 86 02 24
    run_txn(1'b1, 32'h4, 2'd2, 1'b0, 32'h2402_8666, 0);
    run_txn(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1);  lit("lw_4",  32'h2402_8666);
    run_txn(1'b0, 32'h5, 2'd0, 1'b1, 32'h0, 3);  lit("lb_5",  32'hFFFF_FF86);
    run_txn(1'b0, 32'h6, 2'd1, 1'b0, 32'h0, 0);  lit("lhu_6", 32'h0000_2402);
    run_txn(1'b0, 32'h4, 2'd1, 1'b1, 32'h0, 2);  lit("lh_4",  32'hFFFF_8666);
    run_txn(1'b1, 32'h2, 2'd0, 1'b0, 32'hAB, 1);
    run_txn(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0);  lit("lw_0",  32'h00AB_0000);
    run_txn(1'b0, 32'h6, 2'd2, 1'b0, 32'h0, 0);
    run_txn(1'b1, 32'h3, 2'd1, 1'b0, 32'h1234, 0);
    idle(2);
    run_txn(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, TO); lit("lw_edge", 32'h2402_8666);
    run_txn(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, TO + 1);
    idle(1);

    // randomized
    for (int t = 0; t < 300; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) != 0) ra[0] = 1'b0;
      if ($urandom_range(0, 1) != 0) ra[1] = 1'b0;
      run_txn(1'($urandom), ra, 2'($urandom_range(0, 2)), 1'($urandom), $urandom,
              ($urandom_range(0, 11) == 0) ? $urandom_range(14, 19) : $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // reset in the middle of a stalled load
    chk_en = 1'b0;
    @(posedge clk); #1;
    i_req = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h8; i_req_size = 2'd2;
    i_req_signed = 1'b0; i_waitrequest = 1'b1;
    repeat (4) begin @(posedge clk); #1; i_req = 1'b0; i_waitrequest = 1'b1; end
    @(negedge clk);
    chk("midbus_read", 32'(o_read), 1);
    chk("midbus_addr", o_address, 32'h8);
    @(posedge clk); #1; i_reset = 1'b1;
    @(posedge clk); #1; i_reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
